// File: rtl/restore_counter_if.sv
// Request/status bundle for restore_counter; master drives requests, slave returns registered status.
// Parameters must match the counter instance attached to the slave modport.
interface restore_counter_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 1,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              enable;
   logic              decInc;
   logic [STEP_W-1:0] step;
   logic              load;
   logic [WIDTH-1:0]  loadValue;
   logic              saveReq;
   logic              restoreReq;
   logic [WIDTH-1:0]  count;
   logic              wrapPulse;
   logic              restoreErr;
   logic              dropPulse;
   logic [CNT_W-1:0]  stackCount;
   logic              stackFull;
   logic              stackEmpty;

   modport master (
      output enable, decInc, step, load, loadValue, saveReq, restoreReq,
      input  count, wrapPulse, restoreErr, dropPulse, stackCount, stackFull, stackEmpty
   );

   modport slave (
      input  enable, decInc, step, load, loadValue, saveReq, restoreReq,
      output count, wrapPulse, restoreErr, dropPulse, stackCount, stackFull, stackEmpty
   );
endinterface

// File: rtl/restore_counter.sv
// Up/down counter (step 1..2^STEP_W) with LIFO save/restore history; 1-cycle latency, no backpressure.
// RESTORE_COUNTER_SAT_EN selects saturating instead of modular arithmetic.
module restore_counter #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 1,
   parameter int DEPTH  = 4
) (
   input logic             clk,
   input logic             reset,
   restore_counter_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             rerr_q, rerr_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic [PTR_W-1:0] top_q, top_d;
   logic [WIDTH-1:0] stack_q [DEPTH];

   logic             push;
   logic [PTR_W-1:0] next_ptr, prev_ptr;
   logic [WIDTH:0]   mag, sum_inc, sum_dec;

   // One extra bit holds the carry out / borrow of the step.
   assign mag     = (WIDTH+1)'(bus.step) + (WIDTH+1)'(1);
   assign sum_inc = {1'b0, count_q} + mag;
   assign sum_dec = {1'b0, count_q} - mag;

   assign next_ptr = (top_q == PTR_W'(DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
   assign prev_ptr = (top_q == '0) ? PTR_W'(DEPTH - 1) : top_q - PTR_W'(1);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      rerr_d  = 1'b0;
      drop_d  = 1'b0;
      scnt_d  = scnt_q;
      top_d   = top_q;
      push    = 1'b0;

      if (bus.restoreReq) begin
         if (empty_q) begin
            rerr_d = 1'b1;
         end else begin
            count_d = stack_q[top_q];
            top_d   = prev_ptr;
            scnt_d  = scnt_q - CNT_W'(1);
         end
      end else begin
         // A full stack overwrites its oldest slot, which sits just past the top.
         if (bus.saveReq) begin
            push  = 1'b1;
            top_d = next_ptr;
            if (full_q) drop_d = 1'b1;
            else        scnt_d = scnt_q + CNT_W'(1);
         end

         if (bus.load) begin
            count_d = bus.loadValue;
         end else if (bus.enable) begin
            if (!bus.decInc) begin
               wrap_d = sum_inc[WIDTH];
`ifdef RESTORE_COUNTER_SAT_EN
               count_d = sum_inc[WIDTH] ? {WIDTH{1'b1}} : sum_inc[WIDTH-1:0];
`else
               count_d = sum_inc[WIDTH-1:0];
`endif
            end else begin
               wrap_d = sum_dec[WIDTH];
`ifdef RESTORE_COUNTER_SAT_EN
               count_d = sum_dec[WIDTH] ? '0 : sum_dec[WIDTH-1:0];
`else
               count_d = sum_dec[WIDTH-1:0];
`endif
            end
         end
      end

      full_d  = (scnt_d == CNT_W'(DEPTH));
      empty_d = (scnt_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         rerr_q  <= 1'b0;
         drop_q  <= 1'b0;
         scnt_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         top_q   <= '0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         rerr_q  <= rerr_d;
         drop_q  <= drop_d;
         scnt_q  <= scnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         top_q   <= top_d;
      end
   end

   // History contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (push) stack_q[next_ptr] <= count_q;
   end

   assign bus.count      = count_q;
   assign bus.wrapPulse  = wrap_q;
   assign bus.restoreErr = rerr_q;
   assign bus.dropPulse  = drop_q;
   assign bus.stackCount = scnt_q;
   assign bus.stackFull  = full_q;
   assign bus.stackEmpty = empty_q;
endmodule

// File: tb/tb_restore_counter.sv
// Directed + random bench for restore_counter against a queue-based reference model.
module tb_restore_counter;
   localparam int W = 8;
   localparam int S = 1;
   localparam int D = 4;

   typedef struct packed {
      logic [W-1:0] count;
      logic         wrap;
      logic         rerr;
      logic         drop;
      logic [2:0]   scnt;
      logic         full;
      logic         empty;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   restore_counter_if #(.WIDTH(W), .STEP_W(S), .DEPTH(D)) bus ();
   restore_counter #(.WIDTH(W), .STEP_W(S), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   obs_t         exp_q [$];
   int           vectors = 0;
   int           miscompares = 0;
   int           m_count = 0;
   logic [W-1:0] m_stack [$];

   function automatic obs_t sample();
      obs_t o;
      o.count = bus.count;
      o.wrap  = bus.wrapPulse;
      o.rerr  = bus.restoreErr;
      o.drop  = bus.dropPulse;
      o.scnt  = bus.stackCount;
      o.full  = bus.stackFull;
      o.empty = bus.stackEmpty;
      return o;
   endfunction

   function automatic obs_t model_obs(input logic w, input logic re, input logic dr);
      obs_t e;
      e.count = W'(m_count);
      e.wrap  = w;
      e.rerr  = re;
      e.drop  = dr;
      e.scnt  = 3'(m_stack.size());
      e.full  = (m_stack.size() == D);
      e.empty = (m_stack.size() == 0);
      return e;
   endfunction

   task automatic check(input string tag);
      obs_t e;
      obs_t o;
      e = exp_q.pop_front();
      o = sample();
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic check_val(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic cyc(input logic en, input logic dec, input logic st, input logic ld,
                      input logic [W-1:0] lv, input logic sv, input logic rs, input string tag);
      int   t;
      logic w;
      logic re;
      logic dr;
      w  = 1'b0;
      re = 1'b0;
      dr = 1'b0;
      bus.enable     = en;
      bus.decInc     = dec;
      bus.step       = st;
      bus.load       = ld;
      bus.loadValue  = lv;
      bus.saveReq    = sv;
      bus.restoreReq = rs;
      if (rs) begin
         if (m_stack.size() > 0) m_count = int'(m_stack.pop_back());
         else                    re = 1'b1;
      end else begin
         if (sv) begin
            if (m_stack.size() == D) begin
               void'(m_stack.pop_front());
               dr = 1'b1;
            end
            m_stack.push_back(W'(m_count));
         end
         if (ld) begin
            m_count = int'(lv);
         end else if (en) begin
            t = dec ? m_count - (int'(st) + 1) : m_count + (int'(st) + 1);
            if (t > (1 << W) - 1 || t < 0) w = 1'b1;
`ifdef RESTORE_COUNTER_SAT_EN
            if (t > (1 << W) - 1) t = (1 << W) - 1;
            if (t < 0) t = 0;
            m_count = t;
`else
            m_count = t & ((1 << W) - 1);
`endif
         end
      end
      exp_q.push_back(model_obs(w, re, dr));
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic idle(input string tag);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
   endtask

   task automatic ldv(input logic [W-1:0] v, input logic sv, input string tag);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, v, sv, 1'b0, tag);
   endtask

   task automatic restore(input string tag);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, tag);
   endtask

   initial begin
      reset          = 1'b1;
      bus.enable     = 1'b0;
      bus.decInc     = 1'b0;
      bus.step       = '0;
      bus.load       = 1'b0;
      bus.loadValue  = '0;
      bus.saveReq    = 1'b0;
      bus.restoreReq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(model_obs(1'b0, 1'b0, 1'b0));
      check("reset");
      reset = 1'b0;

      // Count by two.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "inc2_a");
      cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "inc2_b");
      cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "inc2_c");
      check_val("inc2_const", int'(bus.count), 6);

      // Top boundary.
      ldv(8'hFF, 1'b0, "load_ff");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "wrap_up");
`ifdef RESTORE_COUNTER_SAT_EN
      check_val("wrap_up_const", int'(bus.count), 255);
`else
      check_val("wrap_up_const", int'(bus.count), 0);
`endif
      check_val("wrap_up_flag", int'(bus.wrapPulse), 1);
      idle("wrap_clear");

      // Back-to-back wraps across the bottom boundary.
      ldv(8'h00, 1'b0, "load_00");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "wrap_dn");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "wrap_b2b");
      ldv(8'h01, 1'b0, "load_01");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, "wrap_dn2");

      // Save alongside a step keeps the pre-step value.
      ldv(8'd10, 1'b0, "load_10");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, "save_step");
      check_val("save_step_const", int'(bus.count), 8);
      restore("restore_10");
      check_val("restore_10_const", int'(bus.count), 10);

      // Empty restore.
      ldv(8'd5, 1'b0, "load_5");
      restore("restore_empty");
      check_val("restore_empty_flag", int'(bus.restoreErr), 1);
      idle("rerr_clear");

      // Overflowing the history.
      ldv(8'd1, 1'b0, "fill_1");
      ldv(8'd2, 1'b1, "fill_2");
      ldv(8'd3, 1'b1, "fill_3");
      ldv(8'd4, 1'b1, "fill_4");
      ldv(8'd5, 1'b1, "fill_5");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "save_drop");
      check_val("save_drop_flag", int'(bus.dropPulse), 1);
      restore("pop_5");
      check_val("pop_5_const", int'(bus.count), 5);
      restore("pop_4");
      restore("pop_3");
      restore("pop_2");
      check_val("pop_2_const", int'(bus.count), 2);
      restore("pop_empty");

      // Priority: restore beats load/enable and suppresses save; load beats enable.
      ldv(8'h20, 1'b0, "load_20");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "save_20");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1, "prio_restore");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, "prio_load");

      // Asynchronous reset with a partially filled history.
      ldv(8'h37, 1'b0, "load_37");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "save_a");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "save_b");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "save_c");
      check_val("pre_reset_depth", int'(bus.stackCount), 3);
      #2;
      reset = 1'b1;
      #1;
      m_count = 0;
      m_stack.delete();
      exp_q.push_back(model_obs(1'b0, 1'b0, 1'b0));
      check("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "post_reset");
      check_val("post_reset_const", int'(bus.count), 1);

      for (int i = 0; i < 80; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
